// File: rtl/vga_timing_pkg.sv
// Shared raster constants and region helpers for the timing generator and text renderer.
package vga_timing_pkg;

   localparam int M1280_H_SYNC  = 112;
   localparam int M1280_H_BACK  = 248;
   localparam int M1280_H_DISP  = 1280;
   localparam int M1280_H_FRONT = 48;
   localparam int M1280_V_SYNC  = 3;
   localparam int M1280_V_BACK  = 38;
   localparam int M1280_V_DISP  = 1024;
   localparam int M1280_V_FRONT = 1;

   localparam int M640_H_SYNC   = 96;
   localparam int M640_H_BACK   = 48;
   localparam int M640_H_DISP   = 640;
   localparam int M640_H_FRONT  = 16;
   localparam int M640_V_SYNC   = 2;
   localparam int M640_V_BACK   = 33;
   localparam int M640_V_DISP   = 480;
   localparam int M640_V_FRONT  = 10;

   function automatic int axis_limit(input int sync_w, input int back_w, input int disp_w,
                                     input int front_w);
      return sync_w + back_w + disp_w + front_w;
   endfunction

   function automatic int disp_start(input int sync_w, input int back_w);
      return sync_w + back_w;
   endfunction

   function automatic int disp_end(input int sync_w, input int back_w, input int disp_w);
      return sync_w + back_w + disp_w;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus sync/active decode of the post-edge position.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int LIMIT = 1688,
   parameter int SYNC  = 112,
   parameter int BACK  = 248,
   parameter int DISP  = 1280,
   parameter int W     = 12
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         wrap,
   output logic         sync,
   output logic         active
);

   localparam int START = disp_start(SYNC, BACK);
   localparam int STOP  = disp_end(SYNC, BACK, DISP);

   logic [W-1:0] count_r;
   logic [W:0]   count_ext_s;

   // position register; count is the value it takes after this edge
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= {W{1'b0}};
      end else begin
         count_r <= count;
      end
   end

   // next position and wrap strobe
   always_comb begin
      count = count_r;
      wrap  = 1'b0;
      if (en) begin
         if (count_r == W'(LIMIT - 1)) begin
            count = {W{1'b0}};
            wrap  = 1'b1;
         end else begin
            count = count_r + {{(W-1){1'b0}}, 1'b1};
         end
      end else begin
         count = count_r;
      end
   end

   // one extra bit so a region ending exactly at 2^W still compares correctly
   assign count_ext_s = {1'b0, count};
   assign sync        = (count_ext_s < (W+1)'(SYNC));
   assign active      = (count_ext_s >= (W+1)'(START)) && (count_ext_s < (W+1)'(STOP));

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: registered sync/enable/coordinates, line/frame strobes,
// look-ahead fetch address and frame-based cursor blink, all advanced by pix_ce.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_SYNC       = M1280_H_SYNC,
   parameter int   H_BACK       = M1280_H_BACK,
   parameter int   H_DISP       = M1280_H_DISP,
   parameter int   H_FRONT      = M1280_H_FRONT,
   parameter int   V_SYNC       = M1280_V_SYNC,
   parameter int   V_BACK       = M1280_V_BACK,
   parameter int   V_DISP       = M1280_V_DISP,
   parameter int   V_FRONT      = M1280_V_FRONT,
   parameter logic HS_POL       = 1'b1,
   parameter logic VS_POL       = 1'b1,
   parameter int   POS_W        = 12,
   parameter int   LOOKAHEAD    = 2,
   parameter int   BLINK_FRAMES = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pix_ce,
   output logic             hs,
   output logic             vs,
   output logic             disp,
   output logic [POS_W-1:0] x_pos,
   output logic [POS_W-1:0] y_pos,
   output logic             line_start,
   output logic             frame_start,
   output logic             fetch_valid,
   output logic [POS_W-1:0] fetch_x,
   output logic [POS_W-1:0] fetch_y,
   output logic             blink
);

   localparam int H_LIMIT = axis_limit(H_SYNC, H_BACK, H_DISP, H_FRONT);
   localparam int V_LIMIT = axis_limit(V_SYNC, V_BACK, V_DISP, V_FRONT);
   localparam int H_START = disp_start(H_SYNC, H_BACK);
   localparam int H_STOP  = disp_end(H_SYNC, H_BACK, H_DISP);
   localparam int V_START = disp_start(V_SYNC, V_BACK);
   localparam int FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [POS_W-1:0] h_next_s, v_next_s;
   logic             h_wrap_s, v_wrap_s, h_sync_s, v_sync_s, h_act_s, v_act_s;
   logic             v_en_s, frame_wrap_s, disp_s, f_hact_s, f_valid_s;
   logic [POS_W:0]   fx_s, fx_off_s;
   logic [POS_W-1:0] x_s, y_s, fx_pos_s, fy_pos_s;
   logic [FC_W-1:0]  fc_r;

   assign v_en_s       = pix_ce & h_wrap_s;
   assign frame_wrap_s = h_wrap_s & v_wrap_s;

   vga_axis_counter #(
      .LIMIT (H_LIMIT), .SYNC (H_SYNC), .BACK (H_BACK), .DISP (H_DISP), .W (POS_W)
   ) u_h (
      .clk (clk), .reset (reset), .en (pix_ce),
      .count (h_next_s), .wrap (h_wrap_s), .sync (h_sync_s), .active (h_act_s)
   );

   vga_axis_counter #(
      .LIMIT (V_LIMIT), .SYNC (V_SYNC), .BACK (V_BACK), .DISP (V_DISP), .W (POS_W)
   ) u_v (
      .clk (clk), .reset (reset), .en (v_en_s),
      .count (v_next_s), .wrap (v_wrap_s), .sync (v_sync_s), .active (v_act_s)
   );

   // decode display and fetch coordinates from the post-edge counters; fetch stays on its line
   always_comb begin
      disp_s   = h_act_s & v_act_s;
      fx_s     = {1'b0, h_next_s} + (POS_W+1)'(LOOKAHEAD);
      fx_off_s = fx_s - (POS_W+1)'(H_START);
      f_hact_s = (fx_s >= (POS_W+1)'(H_START)) && (fx_s < (POS_W+1)'(H_STOP));
      f_valid_s = f_hact_s & v_act_s;
      if (disp_s) begin
         x_s = h_next_s - POS_W'(H_START);
         y_s = v_next_s - POS_W'(V_START);
      end else begin
         x_s = {POS_W{1'b0}};
         y_s = {POS_W{1'b0}};
      end
      if (f_valid_s) begin
         fx_pos_s = fx_off_s[POS_W-1:0];
         fy_pos_s = v_next_s - POS_W'(V_START);
      end else begin
         fx_pos_s = {POS_W{1'b0}};
         fy_pos_s = {POS_W{1'b0}};
      end
   end

   // aligned output registers; strobes last one clk, everything else holds while pix_ce=0
   always_ff @(posedge clk) begin
      if (reset) begin
         hs          <= HS_POL;
         vs          <= VS_POL;
         disp        <= 1'b0;
         x_pos       <= {POS_W{1'b0}};
         y_pos       <= {POS_W{1'b0}};
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         fetch_valid <= 1'b0;
         fetch_x     <= {POS_W{1'b0}};
         fetch_y     <= {POS_W{1'b0}};
      end else if (pix_ce) begin
         hs          <= h_sync_s ? HS_POL : ~HS_POL;
         vs          <= v_sync_s ? VS_POL : ~VS_POL;
         disp        <= disp_s;
         x_pos       <= x_s;
         y_pos       <= y_s;
         line_start  <= h_wrap_s;
         frame_start <= frame_wrap_s;
         fetch_valid <= f_valid_s;
         fetch_x     <= fx_pos_s;
         fetch_y     <= fy_pos_s;
      end else begin
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end
   end

   // blink half-period counter, advanced on each frame wrap
   always_ff @(posedge clk) begin
      if (reset) begin
         fc_r  <= {FC_W{1'b0}};
         blink <= 1'b0;
      end else if (frame_wrap_s) begin
         if (fc_r == FC_W'(BLINK_FRAMES - 1)) begin
            fc_r  <= {FC_W{1'b0}};
            blink <= ~blink;
         end else begin
            fc_r  <= fc_r + {{(FC_W-1){1'b0}}, 1'b1};
         end
      end else begin
         fc_r  <= fc_r;
         blink <= blink;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: small 10x6 mode (LOOKAHEAD 2, blink every 2 frames) plus default-width horizontal timing.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1, pix_ce = 1'b0;
   logic        hs, vs, disp, line_start, frame_start, fetch_valid, blink;
   logic [11:0] x_pos, y_pos, fetch_x, fetch_y;

   logic        reset_b = 1'b1, pix_ce_b = 1'b1;
   logic        b_hs, b_vs, b_disp, b_line_start, b_frame_start, b_fetch_valid, b_blink;
   logic [11:0] b_x_pos, b_y_pos, b_fetch_x, b_fetch_y;

   int n_vec = 0, n_err = 0;
   int m_hc, m_vc, m_frames;
   logic m_ls, m_fs, m_bl;

   vga_timing_gen #(
      .H_SYNC(2), .H_BACK(2), .H_DISP(4), .H_FRONT(2),
      .V_SYNC(1), .V_BACK(1), .V_DISP(3), .V_FRONT(1),
      .HS_POL(1'b0), .VS_POL(1'b0), .POS_W(12), .LOOKAHEAD(2), .BLINK_FRAMES(2)
   ) dut (
      .clk(clk), .reset(reset), .pix_ce(pix_ce), .hs(hs), .vs(vs), .disp(disp),
      .x_pos(x_pos), .y_pos(y_pos), .line_start(line_start), .frame_start(frame_start),
      .fetch_valid(fetch_valid), .fetch_x(fetch_x), .fetch_y(fetch_y), .blink(blink)
   );

   vga_timing_gen #(
      .V_SYNC(1), .V_BACK(1), .V_DISP(3), .V_FRONT(1)
   ) dut_big (
      .clk(clk), .reset(reset_b), .pix_ce(pix_ce_b), .hs(b_hs), .vs(b_vs), .disp(b_disp),
      .x_pos(b_x_pos), .y_pos(b_y_pos), .line_start(b_line_start),
      .frame_start(b_frame_start), .fetch_valid(b_fetch_valid), .fetch_x(b_fetch_x),
      .fetch_y(b_fetch_y), .blink(b_blink)
   );

   function automatic logic [54:0] obs();
      return {hs, vs, disp, line_start, frame_start, fetch_valid, blink,
              x_pos, y_pos, fetch_x, fetch_y};
   endfunction

   // small mode: hs low hc 0-1, vs low vc 0, display hc 4-7 / vc 2-4, fetch display hc 2-5
   function automatic logic [54:0] exp_vec(int hc, int vc, logic ls, logic fs, logic bl);
      logic hs_e, vs_e, d_e, fv_e, vact;
      logic [11:0] x_e, y_e, fx_e, fy_e;
      hs_e = (hc < 2) ? 1'b0 : 1'b1;
      vs_e = (vc < 1) ? 1'b0 : 1'b1;
      vact = (vc >= 2) && (vc < 5);
      d_e  = (hc >= 4) && (hc < 8) && vact;
      fv_e = (hc + 2 >= 4) && (hc + 2 < 8) && vact;
      x_e  = d_e  ? 12'(hc - 4) : 12'd0;
      y_e  = d_e  ? 12'(vc - 2) : 12'd0;
      fx_e = fv_e ? 12'(hc - 2) : 12'd0;
      fy_e = fv_e ? 12'(vc - 2) : 12'd0;
      return {hs_e, vs_e, d_e, ls, fs, fv_e, bl, x_e, y_e, fx_e, fy_e};
   endfunction

   task automatic do_reset();
      reset = 1'b1; pix_ce = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_hc = 0; m_vc = 0; m_ls = 1'b0; m_fs = 1'b0; m_bl = 1'b0; m_frames = 0;
   endtask

   task automatic step(input logic ce);
      pix_ce = ce;
      @(negedge clk);
      if (ce) begin
         m_ls = (m_hc == 9);
         m_fs = m_ls && (m_vc == 5);
         if (m_ls) begin
            m_hc = 0;
            m_vc = (m_vc == 5) ? 0 : m_vc + 1;
         end else begin
            m_hc = m_hc + 1;
         end
         if (m_fs) begin
            m_frames = m_frames + 1;
            m_bl = m_frames[1];
         end
      end else begin
         m_ls = 1'b0; m_fs = 1'b0;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      do_reset();
      n_vec++;
      if (obs() !== 55'h0) begin
         n_err++; $display("FAIL reset_state: got %h want %h", obs(), 55'h0);
      end
   endtask

   task automatic test_small_mode();
      int nls = 0, nfs = 0, fs_at = 0;
      do_reset();
      for (int k = 1; k <= 60; k++) begin
         step(1'b1);
         n_vec++;
         if (obs() !== exp_vec(m_hc, m_vc, m_ls, m_fs, m_bl)) begin
            n_err++; $display("FAIL small_mode edge %0d: got %h want %h", k, obs(),
                              exp_vec(m_hc, m_vc, m_ls, m_fs, m_bl));
         end
         if (line_start) nls++;
         if (frame_start) begin nfs++; fs_at = k; end
      end
      n_vec++;
      if (nls !== 6) begin n_err++; $display("FAIL line_count: got %0d want 6", nls); end
      n_vec++;
      if (nfs !== 1 || fs_at !== 60) begin
         n_err++; $display("FAIL frame_period: got %0d starts at edge %0d want 1 at 60", nfs, fs_at);
      end
   endtask

   task automatic test_reset_mid();
      int nfs = 0, fs_at = 0, guard = 0;
      do_reset();
      while (!(m_hc == 7 && m_vc == 3) && guard < 100) begin step(1'b1); guard++; end
      reset = 1'b1; pix_ce = 1'b1;
      @(negedge clk);
      n_vec++;
      if (obs() !== 55'h0) begin
         n_err++; $display("FAIL reset_mid: got %h want %h", obs(), 55'h0);
      end
      reset = 1'b0;
      m_hc = 0; m_vc = 0; m_ls = 1'b0; m_fs = 1'b0; m_bl = 1'b0; m_frames = 0;
      for (int k = 1; k <= 60; k++) begin
         step(1'b1);
         if (frame_start) begin nfs++; fs_at = k; end
      end
      n_vec++;
      if (nfs !== 1 || fs_at !== 60) begin
         n_err++; $display("FAIL reset_mid_restart: got %0d starts at edge %0d want 1 at 60", nfs, fs_at);
      end
   endtask

   task automatic test_pix_ce();
      int first = 0;
      logic prev_ls = 1'b0;
      do_reset();
      for (int k = 0; k < 200; k++) begin
         step(k % 3 == 2);
         n_vec++;
         if (obs() !== exp_vec(m_hc, m_vc, m_ls, m_fs, m_bl)) begin
            n_err++; $display("FAIL pix_ce clk %0d: got %h want %h", k, obs(),
                              exp_vec(m_hc, m_vc, m_ls, m_fs, m_bl));
         end
         if (line_start && prev_ls) begin
            n_err++; $display("FAIL line_start_width: clk %0d high 2 clks want 1", k);
         end
         prev_ls = line_start;
         if (frame_start && first == 0) first = k + 1;
      end
      n_vec++;
      if (first !== 180) begin
         n_err++; $display("FAIL ce_frame_period: got %0d clks want 180", first);
      end
   endtask

   task automatic test_lookahead();
      logic [9:0] fv_tab, d_tab;
      fv_tab = 10'b00_0011_1100;
      d_tab  = 10'b00_1111_0000;
      do_reset();
      repeat (20) step(1'b1);
      for (int i = 0; i < 10; i++) begin
         if (i > 0) step(1'b1);
         n_vec++;
         if (fetch_valid !== fv_tab[i] || fetch_x !== ((i >= 2 && i < 6) ? 12'(i - 2) : 12'd0)
             || fetch_y !== 12'd0) begin
            n_err++; $display("FAIL fetch hc=%0d: got v=%b x=%0d y=%0d want v=%b", i,
                              fetch_valid, fetch_x, fetch_y, fv_tab[i]);
         end
         n_vec++;
         if (disp !== d_tab[i] || x_pos !== ((i >= 4 && i < 8) ? 12'(i - 4) : 12'd0)) begin
            n_err++; $display("FAIL disp_lead hc=%0d: got d=%b x=%0d want d=%b", i,
                              disp, x_pos, d_tab[i]);
         end
      end
   endtask

   task automatic test_blink();
      logic [6:0] bl_tab;
      int nfs = 0, guard = 0;
      bl_tab = 7'b1100110;
      do_reset();
      while (nfs < 7 && guard < 500) begin
         step(1'b1); guard++;
         if (frame_start) begin
            nfs++;
            n_vec++;
            if (blink !== bl_tab[nfs-1]) begin
               n_err++; $display("FAIL blink frame %0d: got %b want %b", nfs, blink, bl_tab[nfs-1]);
            end
         end
      end
      n_vec++;
      if (nfs !== 7) begin n_err++; $display("FAIL blink_frames: got %0d want 7", nfs); end
   endtask

   task automatic test_big();
      int n = 0;
      reset_b = 1'b1;
      @(negedge clk);
      reset_b = 1'b0;
      do begin @(negedge clk); n++; end while (!b_line_start && n < 2000);
      n_vec++;
      if (n !== 1688) begin n_err++; $display("FAIL big_h_limit: got %0d want 1688", n); end
      n = 0;
      do begin @(negedge clk); n++; end while (!b_disp && n < 5000);
      n_vec++;
      if (n !== 2048 || b_x_pos !== 12'd0 || b_y_pos !== 12'd0 || b_hs !== 1'b0) begin
         n_err++; $display("FAIL big_first_pixel: got %0d x=%0d y=%0d hs=%b want 2048 0 0 0",
                           n, b_x_pos, b_y_pos, b_hs);
      end
      repeat (1279) @(negedge clk);
      n_vec++;
      if (b_disp !== 1'b1 || b_x_pos !== 12'd1279) begin
         n_err++; $display("FAIL big_last_pixel: got d=%b x=%0d want 1 1279", b_disp, b_x_pos);
      end
      @(negedge clk);
      n_vec++;
      if (b_disp !== 1'b0 || b_x_pos !== 12'd0 || b_y_pos !== 12'd0) begin
         n_err++; $display("FAIL big_after_disp: got d=%b x=%0d y=%0d want 0 0 0",
                           b_disp, b_x_pos, b_y_pos);
      end
      repeat (2096) @(negedge clk);
      n_vec++;
      if (b_disp !== 1'b1 || b_x_pos !== 12'd0 || b_y_pos !== 12'd2) begin
         n_err++; $display("FAIL big_last_line: got d=%b x=%0d y=%0d want 1 0 2",
                           b_disp, b_x_pos, b_y_pos);
      end
   endtask

   initial begin
      test_reset();
      test_small_mode();
      test_reset_mid();
      test_pix_ce();
      test_lookahead();
      test_blink();
      test_big();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
